// File: rtl/pc_bank_pkg.sv
// Shared types, defaults and the round-robin search helper for the PC context bank.
package pc_bank_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_NUM_CTX = 5;
    localparam int DEF_CTX_W   = $clog2(DEF_NUM_CTX);
    localparam int MAX_CTX     = 32;
    localparam int MAX_CTX_W   = $clog2(MAX_CTX);

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd4;

    typedef logic [DEF_CTX_W-1:0] ctx_id_t;

    // First set bit of mask scanning cur+1, cur+2, ... and wrapping back to cur.
    // An empty mask returns cur unchanged; cur must be below num_ctx.
    function automatic int unsigned next_rr(input logic [MAX_CTX-1:0] mask,
                                            input int unsigned cur,
                                            input int unsigned num_ctx);
        int unsigned res;
        int unsigned idx;
        logic        found;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CTX; k++) begin
            idx = cur + k;
            if (idx >= num_ctx) begin
                idx = idx - num_ctx;
            end
            if (!found && (k <= num_ctx) && mask[idx[MAX_CTX_W-1:0]]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_context_bank_if.sv
// Control/fetch/debug bundle between the control unit, fetch stage and the PC bank.
interface pc_context_bank_if
    import pc_bank_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int NUM_CTX = DEF_NUM_CTX
);
    localparam int CTX_W = $clog2(NUM_CTX);

    logic               en;
    logic               clear;
    logic               start_valid;
    logic [CTX_W-1:0]   start_id;
    logic [XLEN-1:0]    start_pc;
    logic               stop_valid;
    logic [CTX_W-1:0]   stop_id;
    logic               redirect_valid;
    logic [CTX_W-1:0]   redirect_ctx;
    logic [XLEN-1:0]    redirect_pc;
    logic [CTX_W-1:0]   sel_read;
    logic [XLEN-1:0]    dbg_pc;
    logic               fetch_valid;
    logic [CTX_W-1:0]   fetch_ctx;
    logic [XLEN-1:0]    fetch_pc;
    logic [NUM_CTX-1:0] active_mask;

    // Commands are single-cycle pulses qualified by their *_valid bit and take effect
    // at the next edge; fetch_* is a presentation only (fetch_valid has no ready).
    modport master (
        output en, clear, start_valid, start_id, start_pc, stop_valid, stop_id,
               redirect_valid, redirect_ctx, redirect_pc, sel_read,
        input  dbg_pc, fetch_valid, fetch_ctx, fetch_pc, active_mask
    );

    modport slave (
        input  en, clear, start_valid, start_id, start_pc, stop_valid, stop_id,
               redirect_valid, redirect_ctx, redirect_pc, sel_read,
        output dbg_pc, fetch_valid, fetch_ctx, fetch_pc, active_mask
    );

endinterface

// File: rtl/pc_context_bank_rr_ctx_picker.sv
// Combinational round-robin search: next set bit of mask after cur, wrapping to cur.
module rr_ctx_picker
    import pc_bank_pkg::*;
#(
    parameter int NUM_CTX = DEF_NUM_CTX,
    localparam int CTX_W  = $clog2(NUM_CTX)
) (
    input  logic [NUM_CTX-1:0] mask,
    input  logic [CTX_W-1:0]   cur,
    output logic [CTX_W-1:0]   nxt
);

    int unsigned pick;

    always_comb begin
        pick = next_rr(MAX_CTX'(mask), 32'(cur), NUM_CTX);
        nxt  = CTX_W'(pick);
    end

endmodule

// File: rtl/pc_context_bank.sv
// Multi-context PC bank with round-robin fetch scheduling for a barrel-threaded front end.
module pc_context_bank
    import pc_bank_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              NUM_CTX  = DEF_NUM_CTX,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(DEF_PC_STEP),
    localparam int             CTX_W    = $clog2(NUM_CTX)
) (
    input logic               clk,
    input logic               reset,
    pc_context_bank_if.slave  bus
);

    logic [NUM_CTX-1:0][XLEN-1:0] pc_vec;
    logic [NUM_CTX-1:0]           active_q, active_d, next_mask;
    logic [CTX_W-1:0]             cur_q, cur_d, rr_next;
    logic                         fetch_valid;
    logic [XLEN-1:0]              fetch_pc;
    logic [XLEN-1:0]              dbg_pc;

    always_comb begin
        next_mask = active_q;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (bus.start_valid && (bus.start_id == CTX_W'(i))) begin
                next_mask[i] = 1'b1;
            end
            // Stop is applied after start so it wins on a shared id.
            if (bus.stop_valid && (bus.stop_id == CTX_W'(i))) begin
                next_mask[i] = 1'b0;
            end
        end
    end

    // Index by comparison so out-of-range selects read as zero.
    always_comb begin
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        dbg_pc      = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (cur_q == CTX_W'(i)) begin
                fetch_valid = active_q[i];
                fetch_pc    = pc_vec[i];
            end
            if (bus.sel_read == CTX_W'(i)) begin
                dbg_pc = pc_vec[i];
            end
        end
    end

    rr_ctx_picker #(
        .NUM_CTX (NUM_CTX)
    ) u_picker (
        .mask (next_mask),
        .cur  (cur_q),
        .nxt  (rr_next)
    );

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
        logic [XLEN-1:0] pc_q, pc_d;

        always_comb begin
            pc_d = pc_q;
            if (bus.clear) begin
                pc_d = RESET_PC;
            end else if (bus.start_valid && (bus.start_id == CTX_W'(g))) begin
                pc_d = bus.start_pc;
            end else if (bus.redirect_valid && (bus.redirect_ctx == CTX_W'(g))) begin
                pc_d = bus.redirect_pc;
            end else if (bus.en && fetch_valid && (cur_q == CTX_W'(g))) begin
                pc_d = pc_q + PC_STEP;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q <= RESET_PC;
            end else begin
                pc_q <= pc_d;
            end
        end

        assign pc_vec[g] = pc_q;
    end

    always_comb begin
        cur_d    = cur_q;
        active_d = next_mask;
        if (bus.clear) begin
            cur_d    = '0;
            active_d = active_q;
        end else if (bus.en) begin
            cur_d = rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= NUM_CTX'(1);
            cur_q    <= '0;
        end else begin
            active_q <= active_d;
            cur_q    <= cur_d;
        end
    end

    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_ctx   = cur_q;
    assign bus.fetch_pc    = fetch_pc;
    assign bus.dbg_pc      = dbg_pc;
    assign bus.active_mask = active_q;

endmodule

// File: tb/tb_pc_context_bank.sv
// Scoreboard bench for pc_context_bank: random and directed commands against a reference model.
module tb_pc_context_bank;
    import pc_bank_pkg::*;

    localparam int XLEN = 32;
    localparam int N    = 5;
    localparam int CW   = 3;

    typedef struct packed {
        logic            en;
        logic            clear;
        logic            sv;
        logic [CW-1:0]   sid;
        logic [XLEN-1:0] spc;
        logic            stv;
        logic [CW-1:0]   stid;
        logic            rv;
        logic [CW-1:0]   rctx;
        logic [XLEN-1:0] rpc;
        logic [CW-1:0]   sel;
    } stim_t;

    typedef struct packed {
        logic            fv;
        logic [CW-1:0]   fctx;
        logic [XLEN-1:0] fpc;
        logic [N-1:0]    mask;
        logic [XLEN-1:0] dbg;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_context_bank_if #(.XLEN(XLEN), .NUM_CTX(N)) bus ();

    pc_context_bank #(.XLEN(XLEN), .NUM_CTX(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: plain arrays, one step per clock edge.
    logic [XLEN-1:0] m_pc[N];
    logic [N-1:0]    m_act;
    int              m_cur;

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pc[i] = '0;
        m_act = N'(1);
        m_cur = 0;
    endtask

    task automatic model_step(input stim_t s);
        logic [N-1:0]    nm;
        logic [XLEN-1:0] np[N];
        int              nc;
        logic            found;
        logic            issuing;
        if (s.clear) begin
            for (int i = 0; i < N; i++) m_pc[i] = '0;
            m_cur = 0;
            return;
        end
        nm = m_act;
        if (s.sv && int'(s.sid) < N) nm[s.sid] = 1'b1;
        if (s.stv && int'(s.stid) < N) nm[s.stid] = 1'b0;
        issuing = s.en && m_act[m_cur];
        for (int i = 0; i < N; i++) begin
            if (s.sv && int'(s.sid) == i) np[i] = s.spc;
            else if (s.rv && int'(s.rctx) == i) np[i] = s.rpc;
            else if (issuing && m_cur == i) np[i] = m_pc[i] + 32'd4;
            else np[i] = m_pc[i];
        end
        if (s.en) begin
            nc    = m_cur;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && nm[(m_cur + k) % N]) begin
                    nc    = (m_cur + k) % N;
                    found = 1'b1;
                end
            end
            m_cur = nc;
        end
        for (int i = 0; i < N; i++) m_pc[i] = np[i];
        m_act = nm;
    endtask

    function automatic stim_t idle(input logic en);
        stim_t s;
        s     = '0;
        s.en  = en;
        s.sel = CW'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.en             = s.en;
        bus.clear          = s.clear;
        bus.start_valid    = s.sv;
        bus.start_id       = s.sid;
        bus.start_pc       = s.spc;
        bus.stop_valid     = s.stv;
        bus.stop_id        = s.stid;
        bus.redirect_valid = s.rv;
        bus.redirect_ctx   = s.rctx;
        bus.redirect_pc    = s.rpc;
        bus.sel_read       = s.sel;
    endtask

    // One cycle: drive commands, record what the DUT must present now, advance the model.
    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(s);
        e.fv   = m_act[m_cur];
        e.fctx = CW'(m_cur);
        e.fpc  = m_pc[m_cur];
        e.mask = m_act;
        e.dbg  = (int'(s.sel) < N) ? m_pc[s.sel] : '0;
        exp_q.push_back(EXP_W'(e));
        model_step(s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply('0);
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
                chk("fetch_ctx",   32'(bus.fetch_ctx),   32'(e.fctx));
                chk("fetch_pc",    bus.fetch_pc,         e.fpc);
                chk("active_mask", 32'(bus.active_mask), 32'(e.mask));
                chk("dbg_pc",      bus.dbg_pc,           e.dbg);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        reset = 1'b1;
        apply('0);
        model_reset();
        do_reset();
        do_reset();

        // Single context after reset issues every cycle.
        for (int i = 0; i < 3; i++) drive(idle(1'b1));

        // Bring up ctx 2 and ctx 4, then let them interleave with ctx 0.
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd2; s.spc = 32'h100; drive(s);
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd4; s.spc = 32'h200; drive(s);
        for (int i = 0; i < 6; i++) drive(idle(1'b1));

        // Redirect ctx 2 in its own issue slot, then redirect+start together.
        for (int t = 0; t < 6 && m_cur != 2; t++) drive(idle(1'b1));
        s = idle(1'b1); s.rv = 1'b1; s.rctx = 3'd2; s.rpc = 32'h400; s.sel = 3'd2; drive(s);
        for (int t = 0; t < 6 && m_cur != 2; t++) drive(idle(1'b1));
        s = idle(1'b1); s.rv = 1'b1; s.rctx = 3'd2; s.rpc = 32'h400;
        s.sv = 1'b1; s.sid = 3'd2; s.spc = 32'h500; s.sel = 3'd2; drive(s);
        for (int i = 0; i < 4; i++) drive(idle(1'b1));

        // Stop everything, then restart from an empty mask.
        for (int c = 0; c < N; c++) begin
            s = idle(1'b1); s.stv = 1'b1; s.stid = CW'(c); drive(s);
        end
        for (int i = 0; i < 3; i++) drive(idle(1'b1));
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd3; s.spc = 32'h80; drive(s);
        for (int i = 0; i < 2; i++) drive(idle(1'b1));

        // Start and stop the same context.
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd1; s.spc = 32'h1234;
        s.stv = 1'b1; s.stid = 3'd1; s.sel = 3'd1; drive(s);
        s = idle(1'b1); s.sel = 3'd1; drive(s);

        // PC wrap at the top of the address space.
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd1; s.spc = 32'hFFFF_FFFC; drive(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(1'b1); s.sel = 3'd1; drive(s);
        end

        // Stop current context with en low, then with en high.
        s = idle(1'b0); s.stv = 1'b1; s.stid = CW'(m_cur); drive(s);
        drive(idle(1'b0));
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd0; s.spc = 32'h40; drive(s);
        s = idle(1'b1); s.stv = 1'b1; s.stid = CW'(m_cur); drive(s);
        for (int i = 0; i < 3; i++) drive(idle(1'b1));

        // Clear mid-rotation keeps the mask.
        s = idle(1'b1); s.clear = 1'b1; s.sv = 1'b1; s.sid = 3'd2; s.spc = 32'h999; drive(s);
        for (int i = 0; i < 3; i++) drive(idle(1'b1));

        // Out-of-range ids and debug select.
        s = idle(1'b1); s.sv = 1'b1; s.sid = 3'd7; s.spc = 32'h777;
        s.stv = 1'b1; s.stid = 3'd7; s.rv = 1'b1; s.rctx = 3'd7; s.rpc = 32'h666; s.sel = 3'd6;
        drive(s);
        s = idle(1'b1); s.sel = 3'd6; drive(s);

        for (int i = 0; i < 500; i++) begin
            s       = idle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            s.clear = ($urandom_range(0, 39) == 0);
            s.sv    = ($urandom_range(0, 3) == 0);
            s.sid   = CW'($urandom_range(0, 7));
            s.spc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            s.stv   = ($urandom_range(0, 5) == 0);
            s.stid  = CW'($urandom_range(0, 7));
            s.rv    = ($urandom_range(0, 3) == 0);
            s.rctx  = CW'($urandom_range(0, 7));
            s.rpc   = $urandom() & 32'hFFFF_FFFC;
            drive(s);
        end

        drive(idle(1'b1));
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
